// File: rtl/q15_pkg.sv
// Shared Q1.15 definitions for the mult/complex_mult/divider family.
package q15_pkg;
  localparam int Q_W = 16;
  localparam logic signed [Q_W-1:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [Q_W-1:0] Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {DIV_IDLE, DIV_CALC, DIV_DONE} div_state_t;

  // Magnitude is one bit wider so |Q_MIN| = 0x8000 stays representable.
  function automatic logic [Q_W:0] q15_abs(input logic signed [Q_W-1:0] x);
    logic [Q_W:0] e;
    e = {x[Q_W-1], x};
    return x[Q_W-1] ? -e : e;
  endfunction
endpackage

// File: rtl/q15_divider.sv
// Sequential signed Q1.(W-1) divider: quot = (num<<(W-1))/den, truncated toward zero, saturating.
// Radix-2 restoring division on magnitudes; trivial cases resolve in one cycle.
module q15_divider
  import q15_pkg::*;
#(
  parameter int W = Q_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] num,
  input  logic [W-1:0] den,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] quot,
  output logic         sat,
  output logic         dbz
);
  localparam int CW = $clog2(W);
  localparam logic [W-1:0]  QMAX = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0]  QMIN = {1'b1, {(W-1){1'b0}}};
  localparam logic [CW-1:0] LAST = CW'(W-2);

  function automatic logic [W:0] mag(input logic [W-1:0] x);
    logic [W:0] e;
    e = {x[W-1], x};
    return x[W-1] ? -e : e;
  endfunction

  div_state_t    state, state_nx;
  logic [W:0]    rem, den_mag, num_mag_in, den_mag_in, rem_sh, rem_nx;
  logic [W-2:0]  q, q_nx;
  logic [CW-1:0] cnt;
  logic          sgn, sgn_in, ge, last, fast, fast_sat, fast_dbz;
  logic [W-1:0]  fast_quot;

  assign num_mag_in = mag(num);
  assign den_mag_in = mag(den);
  assign sgn_in     = num[W-1] ^ den[W-1];

  // Cases that need no iteration: divide-by-zero, zero dividend, |quotient| >= 1.
  always_comb begin
    fast      = 1'b1;
    fast_quot = '0;
    fast_sat  = 1'b0;
    fast_dbz  = 1'b0;
    if (den == '0) begin
      fast_dbz  = 1'b1;
      fast_quot = num[W-1] ? QMIN : ((num != '0) ? QMAX : '0);
    end else if (num == '0) begin
      fast_quot = '0;
    end else if (num_mag_in == den_mag_in) begin
      fast_quot = sgn_in ? QMIN : QMAX;
      fast_sat  = ~sgn_in;
    end else if (num_mag_in > den_mag_in) begin
      fast_quot = sgn_in ? QMIN : QMAX;
      fast_sat  = 1'b1;
    end else begin
      fast = 1'b0;
    end
  end

  // One restoring step; rem < den_mag <= 2^(W-1) so the shift fits in W+1 bits.
  always_comb begin
    rem_sh = rem << 1;
    ge     = (rem_sh >= den_mag);
    rem_nx = ge ? (rem_sh - den_mag) : rem_sh;
    q_nx   = {q[W-3:0], ge};
    last   = (cnt == LAST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= DIV_IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      DIV_IDLE: if (in_valid) state_nx = fast ? DIV_DONE : DIV_CALC;
      DIV_CALC: if (last)     state_nx = DIV_DONE;
      DIV_DONE: if (out_ready) state_nx = DIV_IDLE;
      default:                state_nx = DIV_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == DIV_IDLE);
    out_valid = (state == DIV_DONE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem     <= '0;
      den_mag <= '0;
      q       <= '0;
      cnt     <= '0;
      sgn     <= 1'b0;
      quot    <= '0;
      sat     <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      case (state)
        DIV_IDLE: if (in_valid) begin
          sgn     <= sgn_in;
          rem     <= num_mag_in;
          den_mag <= den_mag_in;
          q       <= '0;
          cnt     <= '0;
          if (fast) begin
            quot <= fast_quot;
            sat  <= fast_sat;
            dbz  <= fast_dbz;
          end
        end
        DIV_CALC: begin
          rem <= rem_nx;
          q   <= q_nx;
          cnt <= cnt + 1'b1;
          // q <= QMAX here, so negation cannot overflow.
          if (last) begin
            quot <= sgn ? -{1'b0, q_nx} : {1'b0, q_nx};
            sat  <= 1'b0;
            dbz  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end
endmodule

// File: tb/tb_q15_divider.sv
// Directed table plus corner sequences and a random sweep against an integer-division model.
module tb_q15_divider;
  import q15_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [15:0] num, den, quot;
  logic        sat, dbz;

  int nchk = 0;
  int nfail = 0;

  q15_divider #(.W(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .num(num), .den(den),
    .out_valid(out_valid), .out_ready(out_ready),
    .quot(quot), .sat(sat), .dbz(dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] n, d, q;
    logic        s, z;
    int          lat;
  } vec_t;

  vec_t vecs[14];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic do_op(input logic [15:0] n, input logic [15:0] d, input bit tog,
                       output logic [15:0] q, output logic s, output logic z, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!in_ready) begin
      nchk++; nfail++;
      $display("FAIL in_ready_wait: got 0 expected 1");
    end
    num = n; den = d; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; num = 16'hA5A5; den = 16'h0003;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (tog) begin in_valid = ~in_valid; num = 16'($urandom); end
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    q = quot; s = sat; z = dbz;
    if (out_valid) begin @(posedge clk); #1; end
  endtask

  initial begin
    logic [15:0] rq, hq;
    logic        rs, rz, bad;
    int          lat;

    vecs[0]  = '{16'h2000, 16'h4000, 16'h4000, 1'b0, 1'b0, 16};
    vecs[1]  = '{16'hD000, 16'h4000, 16'hA000, 1'b0, 1'b0, 16};
    vecs[2]  = '{16'h1000, 16'hD000, 16'hD556, 1'b0, 1'b0, 16};
    vecs[3]  = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1, 1'b0, 1};
    vecs[4]  = '{16'h4000, 16'hC000, 16'h8000, 1'b0, 1'b0, 1};
    vecs[5]  = '{16'h6000, 16'h2000, 16'h7FFF, 1'b1, 1'b0, 1};
    vecs[6]  = '{16'h1234, 16'h0000, 16'h7FFF, 1'b0, 1'b1, 1};
    vecs[7]  = '{16'h8000, 16'h0000, 16'h8000, 1'b0, 1'b1, 1};
    vecs[8]  = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1};
    vecs[9]  = '{16'h8000, 16'h8000, 16'h7FFF, 1'b1, 1'b0, 1};
    vecs[10] = '{16'h8000, 16'h4000, 16'h8000, 1'b1, 1'b0, 1};
    vecs[11] = '{16'h0000, 16'h1234, 16'h0000, 1'b0, 1'b0, 1};
    vecs[12] = '{16'h7FFE, 16'h7FFF, 16'h7FFE, 1'b0, 1'b0, 16};
    vecs[13] = '{16'hFFFF, 16'h8000, 16'h0001, 1'b0, 1'b0, 16};

    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; num = '0; den = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst out_valid", 32'(out_valid), 32'd0);
    chk("rst quot", 32'(quot), 32'd0);
    chk("rst sat", 32'(sat), 32'd0);
    chk("rst dbz", 32'(dbz), 32'd0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      do_op(vecs[i].n, vecs[i].d, 1'b0, rq, rs, rz, lat);
      chk($sformatf("v%0d quot", i), 32'(rq), 32'(vecs[i].q));
      chk($sformatf("v%0d sat", i), 32'(rs), 32'(vecs[i].s));
      chk($sformatf("v%0d dbz", i), 32'(rz), 32'(vecs[i].z));
      chk($sformatf("v%0d latency", i), 32'(lat), 32'(vecs[i].lat));
      chk($sformatf("v%0d in_ready_after", i), 32'(in_ready), 32'd1);
    end

    // Backpressure: result must hold while out_ready is low.
    out_ready = 1'b0;
    num = 16'h4000; den = 16'h8000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; num = 16'h1111; den = 16'h2222;
    lat = 1;
    while (!out_valid && lat < 40) begin @(posedge clk); #1; lat++; end
    chk("hold latency", 32'(lat), 32'd16);
    hq = quot;
    chk("hold quot", 32'(hq), 32'h0000C000);
    for (int c = 0; c < 5; c++) begin
      in_valid = c[0];
      @(posedge clk); #1;
      chk($sformatf("hold%0d quot", c), 32'(quot), 32'(hq));
      chk($sformatf("hold%0d out_valid", c), 32'(out_valid), 32'd1);
      chk($sformatf("hold%0d in_ready", c), 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("hold release out_valid", 32'(out_valid), 32'd0);
    chk("hold release in_ready", 32'(in_ready), 32'd1);

    // in_valid and num toggling while busy must be ignored.
    do_op(16'h2000, 16'h4000, 1'b1, rq, rs, rz, lat);
    chk("toggle quot", 32'(rq), 32'h00004000);
    chk("toggle latency", 32'(lat), 32'd16);

    // Reset partway through the iteration aborts the operation.
    num = 16'h2000; den = 16'h4000; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst out_valid", 32'(out_valid), 32'd0);
    chk("midrst in_ready", 32'(in_ready), 32'd1);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;
    chk("postrst in_ready", 32'(in_ready), 32'd1);
    bad = 1'b0;
    repeat (20) begin @(posedge clk); #1; if (out_valid) bad = 1'b1; end
    chk("postrst no stale result", 32'(bad), 32'd0);

    // Random normal-path sweep.
    for (int k = 0; k < 1000; k++) begin
      logic [15:0] d, n, e;
      logic [16:0] dm;
      int          nm, qi, prod, diff;
      d = 16'($urandom);
      dm = q15_abs(d);
      while (dm < 17'd2) begin d = 16'($urandom); dm = q15_abs(d); end
      nm = int'($urandom_range(1, int'(dm) - 1));
      n = $urandom_range(0, 1) ? 16'(-nm) : 16'(nm);
      qi = (nm <<< 15) / int'(dm);
      e = (n[15] ^ d[15]) ? 16'(-qi) : 16'(qi);
      do_op(n, d, 1'b0, rq, rs, rz, lat);
      chk($sformatf("rnd%0d n=%h d=%h quot", k, n, d), 32'(rq), 32'(e));
      chk($sformatf("rnd%0d latency", k), 32'(lat), 32'd16);
      prod = ($signed(rq) * $signed(d)) >>> 15;
      diff = $signed(n) - prod;
      if (diff < 0) diff = -diff;
      chk($sformatf("rnd%0d mult residual ok", k),
          32'(diff <= (int'(dm) >> 15) + 1), 32'd1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
    $finish;
  end
endmodule
